vmem_write_arbiter: RTL
=======================

Name: vmem_write_arbiter

Overview:
- Shares the single video-memory write path between four writer clients (CPU port, blitter, palette loader, test pattern).
- Round-robin arbitration picks one request per cycle and pushes its address/data pair into a small write FIFO.
- The FIFO head drives the memory unit's write address and write data inputs.
- The head entry is popped each time the memory unit signals that a write slot has consumed it (its WriteDataRdy strobe).

Parameters:
AWIDTH, 19, memory address width
DWIDTH, 8, memory data width
DEPTH, 4, FIFO entries (power of two, 2..16)
PTRW, 2, log2(DEPTH)

Ports:
MemClk  in  1  memory clock; all state on rising edge
Reset  in  1  asynchronous, active-high reset
ReqValid  in  4  per-client write request, bit n = client n
ReqAddr1..ReqAddr4  in  AWIDTH each  client write address
ReqData1..ReqData4  in  DWIDTH each  client write data
ReqAck  out  4  one-hot, combinational; client n's request accepted at this edge
SlotTake  in  1  pulse from memory unit: current write slot consumes FIFO head
WrAddr  out  AWIDTH  FIFO head address
WrData  out  DWIDTH  FIFO head data
WrValid  out  1  FIFO non-empty
Full  out  1  Level == DEPTH
Level  out  PTRW+1  current entry count
Underrun  out  1  registered one-cycle pulse: SlotTake arrived with FIFO empty
UnderrunCnt  out  8  saturating count of underruns

Behaviour:
- Reset (async, any time, including mid-transfer):
  - Level=0, head/tail pointers=0, LastGrant=3 (client 0 has first priority).
  - Underrun=0, UnderrunCnt=0.
  - All outputs low: WrValid=0, Full=0, ReqAck=0.
  - FIFO contents are don't-care; WrAddr/WrData are don't-care while WrValid=0.
- Pop:
  - Pop = SlotTake & WrValid.
  - Head pointer advances by one on the edge, wrapping modulo DEPTH.
  - WrAddr/WrData are driven from the entry at the head pointer (combinational read), so the new head appears the cycle after the pop.
- Push capacity: CanPush = (Level < DEPTH) | Pop. A push into a full FIFO is allowed in the same cycle as a pop.
- Arbitration (combinational):
  - Search order is LastGrant+1, +2, +3, +4 (mod 4).
  - The first client with ReqValid set is the winner.
  - ReqAck[winner] = CanPush; all other ReqAck bits = 0.
  - If ReqValid=0, ReqAck=0.
- Push:
  - On an edge with any ReqAck bit set, the winner's ReqAddr/ReqData are written at the tail pointer.
  - Tail pointer advances (wraps modulo DEPTH); LastGrant takes the winner index.
  - LastGrant is unchanged when there is no push.
- Requester contract:
  - A client holds ReqValid/ReqAddr/ReqData stable until it samples ReqAck=1 on an edge.
  - It may present the next request in the following cycle.
- Level update:
  - +1 on push only; -1 on pop only; unchanged on push+pop or neither.
  - Level never exceeds DEPTH and never goes below 0.
- Empty handling: SlotTake with WrValid=0 changes no pointers. Underrun=1 on the next cycle; UnderrunCnt increments, saturating at 255.
- Throughput and latency:
  - Throughput is one accepted write per cycle.
  - An accepted write reaches WrAddr/WrData one cycle after acceptance if the FIFO was empty.
- Fairness: with all four clients continuously requesting and free space available, grants cycle 0,1,2,3,0,...
- Stalled clients keep ReqValid high; there is no timeout or drop.
- Data ordering is strict FIFO by acceptance order.

Test Plan:
- Reset, then client 2 requests Addr=0x12345, Data=0xA5 for one cycle → ReqAck=0100 that cycle. Next cycle WrValid=1, WrAddr=0x12345, WrData=0xA5, Level=1. SlotTake pulse → WrValid=0, Level=0.
- All four ReqValid held high, SlotTake tied high → ReqAck sequence 0001,0010,0100,1000,0001. WrData order matches the clients' data values. Level stays ≤1.
- Clients push 5 writes with SlotTake=0, DEPTH=4 → the first 4 are acked, Full=1, Level=4, 5th ReqAck=0. Raise SlotTake for one cycle → the 5th is acked on the same edge and Level stays 4. Head data is entry 2.
- FIFO empty, SlotTake pulsed 3 times → Underrun pulses 3 times, UnderrunCnt=3, Level=0, pointers unchanged. Then 300 underruns → UnderrunCnt saturates at 255.
- FIFO holding 3 entries and client 1 mid-request → assert Reset asynchronously between edges. Outputs clear immediately: WrValid=0, Full=0, Level=0, ReqAck=0. After release, client 0 gets priority over client 1.
- Wrap-around: push 10 and pop 10 interleaved, values 0x01..0x0A → WrData pops 0x01..0x0A in order. Level returns to 0 with no spurious Full.

Source files
------------

// File: rtl/vmem_write_arbiter.sv
// Round-robin arbiter that funnels four write clients into a small FIFO
// whose head feeds the video memory write port.
module vmem_write_arbiter #(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int PTRW   = 2
) (
  input  logic              MemClk,
  input  logic              Reset,
  input  logic [3:0]        ReqValid,
  input  logic [AWIDTH-1:0] ReqAddr1,
  input  logic [AWIDTH-1:0] ReqAddr2,
  input  logic [AWIDTH-1:0] ReqAddr3,
  input  logic [AWIDTH-1:0] ReqAddr4,
  input  logic [DWIDTH-1:0] ReqData1,
  input  logic [DWIDTH-1:0] ReqData2,
  input  logic [DWIDTH-1:0] ReqData3,
  input  logic [DWIDTH-1:0] ReqData4,
  output logic [3:0]        ReqAck,
  input  logic              SlotTake,
  output logic [AWIDTH-1:0] WrAddr,
  output logic [DWIDTH-1:0] WrData,
  output logic              WrValid,
  output logic              Full,
  output logic [PTRW:0]     Level,
  output logic              Underrun,
  output logic [7:0]        UnderrunCnt
);

  localparam logic [PTRW:0] L_DEPTH = (PTRW+1)'(DEPTH);

  logic [AWIDTH-1:0] r_mem_addr [DEPTH];
  logic [DWIDTH-1:0] r_mem_data [DEPTH];
  logic [PTRW-1:0]   r_head;
  logic [PTRW-1:0]   r_tail;
  logic [PTRW:0]     r_level;
  logic [1:0]        r_last_grant;
  logic              r_underrun;
  logic [7:0]        r_underrun_cnt;

  logic              w_pop;
  logic              w_push;
  logic              w_can_push;
  logic              w_found;
  logic [1:0]        w_win;
  logic [AWIDTH-1:0] w_win_addr;
  logic [DWIDTH-1:0] w_win_data;

  assign WrValid     = (r_level != '0);
  assign Full        = (r_level == L_DEPTH);
  assign Level       = r_level;
  assign WrAddr      = r_mem_addr[r_head];
  assign WrData      = r_mem_data[r_head];
  assign Underrun    = r_underrun;
  assign UnderrunCnt = r_underrun_cnt;

  assign w_pop      = SlotTake & WrValid;
  // A full FIFO still accepts a write on the same edge its head is consumed.
  assign w_can_push = (r_level < L_DEPTH) | w_pop;

  // Search starts just after the last winner so each client gets a turn.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last_grant + 2'(k);
      if (!w_found && ReqValid[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  always_comb begin
    w_win_addr = ReqAddr1;
    w_win_data = ReqData1;
    case (w_win)
      2'd0: begin w_win_addr = ReqAddr1; w_win_data = ReqData1; end
      2'd1: begin w_win_addr = ReqAddr2; w_win_data = ReqData2; end
      2'd2: begin w_win_addr = ReqAddr3; w_win_data = ReqData3; end
      default: begin w_win_addr = ReqAddr4; w_win_data = ReqData4; end
    endcase
  end

  // Reset is folded in so the acknowledge drops the moment reset asserts.
  assign w_push = w_found & w_can_push & ~Reset;
  assign ReqAck = w_push ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge MemClk) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= w_win_addr;
      r_mem_data[r_tail] <= w_win_data;
    end
  end

  always_ff @(posedge MemClk or posedge Reset) begin
    if (Reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_level      <= '0;
      r_last_grant <= 2'd3;
    end else begin
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_push) begin
        r_tail       <= r_tail + 1'b1;
        r_last_grant <= w_win;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge MemClk or posedge Reset) begin
    if (Reset) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_underrun <= SlotTake & ~WrValid;
      if (SlotTake && !WrValid && r_underrun_cnt != 8'hFF)
        r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

endmodule
